// File: rtl/shift_cmd_queue.sv
// Registered FIFO of shift commands ahead of the arithmetic shifter; out-of-range amounts are normalised on write.
// Optional SHIFT_CMD_QUEUE_STATS_EN adds a saturating count of pushes whose amount is >= N.
module shift_cmd_queue #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    localparam int A    = $clog2(N),
    localparam int P    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [A:0]   in_amount,
    input  logic         in_dir,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [A-1:0] out_amount,
    output logic         out_dir,
    output logic [P:0]   count
`ifdef SHIFT_CMD_QUEUE_STATS_EN
    ,
    output logic [15:0]  sat_count
`endif
);

    logic [N-1:0] mem_data   [DEPTH];
    logic [A-1:0] mem_amount [DEPTH];
    logic         mem_dir    [DEPTH];

    logic [P-1:0] wr_ptr, rd_ptr;
    logic         push, pop;
    logic         over_range;
    logic [N-1:0] wr_data;
    logic [A-1:0] wr_amount;

    assign in_ready  = (count != (P+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The amount range is 0..2N-1, so its top bit alone means "shift by N or more".
    assign over_range = in_amount[A];

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        wr_data   = in_data;
        wr_amount = in_amount[A-1:0];
        if (over_range) begin
            wr_amount = '0;
            wr_data   = in_dir ? {N{in_data[N-1]}} : '0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: storage is reset too, so the head outputs read 0 while the queue is empty after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i]   <= '0;
                mem_amount[i] <= '0;
                mem_dir[i]    <= 1'b0;
            end
        end else begin
            if (push) begin
                mem_data[wr_ptr]   <= wr_data;
                mem_amount[wr_ptr] <= wr_amount;
                mem_dir[wr_ptr]    <= in_dir;
                wr_ptr             <= wr_ptr + P'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + P'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (P+1)'(1);
                2'b01:   count <= count - (P+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry drives the shifter straight from storage.
    assign out_data   = mem_data[rd_ptr];
    assign out_amount = mem_amount[rd_ptr];
    assign out_dir    = mem_dir[rd_ptr];

`ifdef SHIFT_CMD_QUEUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (push && over_range && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_cmd_queue.sv
// Scoreboard bench for shift_cmd_queue (N=8, DEPTH=4): directed cases plus randomized traffic
// checked against a queue-based reference model and an arithmetic shift reference.
module tb_shift_cmd_queue;

    localparam int N     = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        logic [3:0] amt;
        logic       dir;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [3:0] in_amount = '0;
    logic       in_dir = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_amount;
    logic       out_dir;
    logic [2:0] count;
`ifdef SHIFT_CMD_QUEUE_STATS_EN
    logic [15:0] sat_count;
    logic [15:0] sat_exp = '0;
`endif

    int   errors = 0;
    int   checks = 0;
    cmd_t sb[$];

    shift_cmd_queue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amount  (in_amount),
        .in_dir     (in_dir),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_amount (out_amount),
        .out_dir    (out_dir),
        .count      (count)
`ifdef SHIFT_CMD_QUEUE_STATS_EN
        ,
        .sat_count  (sat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Mathematical shift of a signed N-bit value: multiply or floor-divide by 2 per step.
    function automatic logic [7:0] shift_ref(input logic [7:0] d, input logic [3:0] amt, input logic dir);
        int v;
        v = int'($signed(d));
        for (int i = 0; i < int'(amt); i++) begin
            if (dir) v = (v < 0 && (v % 2) != 0) ? (v - 1) / 2 : v / 2;
            else     v = v * 2;
        end
        return 8'(v);
    endfunction

    // What the queue should hold for a command: unchanged if representable, else the saturated result.
    function automatic cmd_t stored(input cmd_t c);
        cmd_t s;
        s = c;
        if (int'(c.amt) >= N) begin
            s.amt  = '0;
            s.data = c.dir ? (c.data[7] ? 8'hFF : 8'h00) : 8'h00;
        end
        return s;
    endfunction

    // Monitor: compares occupancy, the presented head, and records pushes.
    always @(negedge clk) begin
        cmd_t e;
        cmd_t c;
        if (rst_n) begin
            check("count", 32'(count), 32'(sb.size()));
            check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
            check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (out_valid && sb.size() > 0) begin
                e = stored(sb[0]);
                check("head_data", 32'(out_data), 32'(e.data));
                check("head_amount", 32'(out_amount), 32'(e.amt));
                check("head_dir", 32'(out_dir), 32'(e.dir));
                check("shift_result", 32'(shift_ref(out_data, {1'b0, out_amount}, out_dir)),
                      32'(shift_ref(sb[0].data, sb[0].amt, sb[0].dir)));
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready) begin
                c.data = in_data;
                c.amt  = in_amount;
                c.dir  = in_dir;
                sb.push_back(c);
`ifdef SHIFT_CMD_QUEUE_STATS_EN
                if (int'(in_amount) >= N && sat_exp != 16'hFFFF) sat_exp++;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] d, input logic [3:0] a, input logic dir);
        logic acc;
        acc       = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        in_dir    = dir;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) break;
        end
        check("push_accepted", 32'(acc), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 50 && count != 0; t++) step();
        check("drained", 32'(count), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_amount"}, 32'(out_amount), 32'd0);
        check({tag, "_out_dir"}, 32'(out_dir), 32'd0);
`ifdef SHIFT_CMD_QUEUE_STATS_EN
        check({tag, "_sat_count"}, 32'(sat_count), 32'd0);
`endif
    endtask

    initial begin
        logic acc;
        // Reset and idle.
        #17;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        step();
        check_reset_outputs("idle");

        // Single command: visible after the accepting edge, no bypass.
        push_cmd(8'hA5, 4'd3, 1'b1);
        check("a5_valid", 32'(out_valid), 32'd1);
        check("a5_data", 32'(out_data), 32'hA5);
        check("a5_amount", 32'(out_amount), 32'd3);
        check("a5_dir", 32'(out_dir), 32'd1);
        drain();

        // Out-of-range amounts.
        push_cmd(8'h96, 4'd9, 1'b1);
        push_cmd(8'h16, 4'd12, 1'b1);
        push_cmd(8'h96, 4'd8, 1'b0);
`ifdef SHIFT_CMD_QUEUE_STATS_EN
        check("sat_count_3", 32'(sat_count), 32'd3);
`endif
        drain();

        // Fill, refuse a fifth command, then one pop lets it in.
        for (int i = 0; i < DEPTH; i++) push_cmd(8'(8'h10 + i), 4'(i), 1'(i % 2));
        check("full_count", 32'(count), 32'd4);
        in_valid  = 1'b1;
        in_data   = 8'h55;
        in_amount = 4'd1;
        in_dir    = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_hold_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("refill_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("refill_count", 32'(count), 32'd4);
        drain();

        // Steady state at count 2 with simultaneous push and pop, across pointer wrap.
        push_cmd(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
        push_cmd(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) push_cmd(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom));
        check("steady_count", 32'(count), 32'd2);
        out_ready = 1'b0;
        drain();

        // Randomized traffic; a refused command is held until accepted.
        acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (!in_valid || acc) begin
                in_valid  = 1'($urandom_range(0, 3) != 0);
                in_data   = 8'($urandom);
                in_amount = 4'($urandom_range(0, 15));
                in_dir    = 1'($urandom);
            end
            out_ready = 1'($urandom_range(0, 2) != 0);
        end
        in_valid = 1'b0;
        drain();

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++) push_cmd(8'(8'hC0 + i), 4'(i + 1), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        sb.delete();
`ifdef SHIFT_CMD_QUEUE_STATS_EN
        sat_exp = '0;
`endif
        step();
        step();
        #1;
        rst_n = 1'b1;
        step();
        check_reset_outputs("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule

// File: doc/shift_cmd_queue.md
# shift_cmd_queue

Registered command queue sitting directly upstream of the combinational arithmetic shifter. Accepts shift commands (data, amount, direction) over a valid/ready handshake and buffers up to DEPTH of them. Normalises out-of-range shift amounts into a form the shifter's log2(N)-bit amount port can express. Presents the head command to the shifter from flops, so the shifter's inputs never see upstream combinational paths.

## Interface
- N, default 8: data width; power of 2, ≥ 2; must match the downstream shifter's N.
- DEPTH, default 4: queue entries; power of 2, ≥ 2.
- A = $clog2(N); P = $clog2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream command valid.
- in_ready  out  1  queue can accept a command.
- in_data  in  N  signed operand.
- in_amount  in  A+1  shift amount; range 0..2N-1.
- in_dir  in  1  0 = left, 1 = arithmetic right.
- out_valid  out  1  head command valid toward the shifter.
- out_ready  in  1  consumer accepts the head command.
- out_data  out  N  to shifter data_in.
- out_amount  out  A  to shifter shift_amount.
- out_dir  out  1  to shifter direction.
- count  out  P+1  current occupancy, 0..DEPTH.

## Operation
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It is not combinationally dependent on out_ready: a full queue refuses a push even when a pop happens in the same cycle.
- out_valid = (count != 0).
- out_data, out_amount and out_dir come straight from the storage entry at the read pointer; no combinational logic after the flops.
- Normalisation is applied at write time:
  - If in_amount < N, store in_data unchanged, store in_amount[A-1:0], store in_dir.
  - If in_amount ≥ N and in_dir = 0, store data 0, amount 0, dir 0.
  - If in_amount ≥ N and in_dir = 1, store {N{in_data[N-1]}}, amount 0, dir 1.
- The shifter's result therefore equals the mathematically correct shift for every amount in 0..2N-1.
- Pointers are P bits wide and wrap modulo DEPTH.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged; both pointers advance.
- Ordering is strict FIFO.
- No state machine beyond the pointers and count.
- Reset clears count, both pointers and every storage entry to 0. After reset: in_ready = 1, out_valid = 0, out_data = 0, out_amount = 0, out_dir = 0, count = 0.
- Reset asserted mid-operation discards all queued commands immediately; there is no drain.

## Timing
- Write latency: a command pushed at edge k into an empty queue gives out_valid = 1 after edge k. There is no same-cycle bypass.
- While out_valid = 1 and out_ready = 0, out_data, out_amount and out_dir hold stable.
- Full to not-full: in_ready rises in the cycle after a pop from a full queue.
- Throughput: one push and one pop per cycle in steady state when DEPTH ≥ 2.
- Upstream must hold in_* stable while in_valid = 1 and in_ready = 0.

## Configuration
- SHIFT_CMD_QUEUE_STATS_EN:
  - When defined, adds output port sat_count (16 bits).
  - sat_count increments on every push whose in_amount ≥ N.
  - It saturates at 16'hFFFF and resets to 0.
  - When undefined, the port and counter do not exist; all other behaviour is identical.

## Test plan
- Reset, then idle: count = 0, in_ready = 1, out_valid = 0, out_data = 0.
- N = 8. Push (8'hA5, amount 3, dir 1) into an empty queue: out_valid = 1 on the next cycle; out_data = A5, out_amount = 3, out_dir = 1.
- Saturation, N = 8:
  - Push (8'h96, amount 9, dir 1): stored as FF/0/1.
  - Push (8'h16, amount 12, dir 1): stored as 00/0/1.
  - Push (8'h96, amount 8, dir 0): stored as 00/0/0.
  - With the macro defined, sat_count = 3.
- Fill DEPTH = 4 with out_ready = 0: in_ready = 0 at count = 4, and a fifth in_valid is not accepted. Then pulse out_ready for one cycle: in_ready = 1 the next cycle, and order is preserved.
- Simultaneous push and pop at count = 2 over 20 cycles with random data: count stays 2 and output order matches input order, including across pointer wrap.
- Assert rst_n low with 3 entries queued: outputs go to reset values immediately. After release, queued entries are gone and count = 0.
